// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv sequencer: state encoding, default watchdog limit
// and the nominal multdiv latencies.
package multdiv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } md_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 48;
  localparam int unsigned MULT_LATENCY    = 17;
  localparam int unsigned DIV_LATENCY     = 34;

  // Counter width able to hold Timeout-1; never narrower than one bit.
  function automatic int unsigned wdog_width(input int unsigned timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/watchdog_counter.sv
// Clear/enable up-counter whose terminal-count flag marks the last permitted WAIT cycle.
module watchdog_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned Timeout = TIMEOUT_DEFAULT,
  parameter int unsigned CntW    = wdog_width(Timeout)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CntW'(Timeout - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and the multi-cycle multdiv unit: latches operands, pulses
// the start strobe, waits for ready under a watchdog and hands the result to writeback.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_is_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [REG_W-1:0]  issue_rd,
  output logic [DATA_W-1:0] md_operandA,
  output logic [DATA_W-1:0] md_operandB,
  output logic              md_ctrl_MULT,
  output logic              md_ctrl_DIV,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              busy,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exception,
  output logic              wb_timeout
);

  md_state_e         state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              is_div_q, is_div_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic              wb_exc_q, wb_exc_d;
  logic              wb_to_q, wb_to_d;
  logic              wdog_clr, wdog_en, wdog_tc;

  watchdog_counter #(
    .Timeout(TIMEOUT)
  ) u_watchdog (
    .clk_i(clock),
    .rst_i(reset),
    .clr_i(wdog_clr),
    .en_i (wdog_en),
    .tc_o (wdog_tc)
  );

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rd_d         = rd_q;
    is_div_d     = is_div_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_exc_d     = wb_exc_q;
    wb_to_d      = wb_to_q;
    issue_ready  = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wdog_clr     = 1'b0;
    wdog_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        issue_ready = 1'b1;
        // Late ready pulses from flushed or reset operations are ignored here.
        if (issue_valid && !flush) begin
          op_a_d   = issue_a;
          op_b_d   = issue_b;
          rd_d     = issue_rd;
          is_div_d = issue_is_div;
          state_d  = StStart;
        end
      end
      StStart: begin
        md_ctrl_DIV  = is_div_q;
        md_ctrl_MULT = !is_div_q;
        wdog_clr     = 1'b1;
        state_d      = flush ? StIdle : StWait;
      end
      StWait: begin
        wdog_en = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else if (md_resultRDY) begin
          wb_data_d = md_result;
          wb_exc_d  = md_exception;
          wb_to_d   = 1'b0;
          wb_rd_d   = rd_q;
          state_d   = StDone;
        end else if (wdog_tc) begin
          wb_data_d = '0;
          wb_exc_d  = 1'b1;
          wb_to_d   = 1'b1;
          wb_rd_d   = rd_q;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (flush || wb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_exc_q  <= 1'b0;
      wb_to_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_exc_q  <= wb_exc_d;
      wb_to_q   <= wb_to_d;
    end
  end

  assign md_operandA  = op_a_q;
  assign md_operandB  = op_b_q;
  assign busy         = (state_q != StIdle) || (issue_valid && !flush);
  assign wb_valid     = (state_q == StDone);
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;
  assign wb_timeout   = wb_to_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed plus randomized bench for multdiv_ctrl with a behavioural multdiv stand-in.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int unsigned TO = TIMEOUT_DEFAULT;

  logic        clock, reset, flush;
  logic        issue_valid, issue_ready, issue_is_div;
  logic [31:0] issue_a, issue_b;
  logic [4:0]  issue_rd;
  logic [31:0] md_operandA, md_operandB, md_result;
  logic        md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY;
  logic        busy, wb_valid, wb_ready, wb_exception, wb_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  multdiv_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_is_div(issue_is_div),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_exception(wb_exception), .wb_timeout(wb_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference arithmetic: returns {exception, result}.
  function automatic logic [32:0] ref_op(input logic div, input logic [31:0] a,
                                         input logic [31:0] b);
    longint p;
    int     q;
    if (!div) begin
      p = longint'(signed'(a)) * longint'(signed'(b));
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = int'(a) / int'(b);
    return {1'b0, q[31:0]};
  endfunction

  // multdiv stand-in: a start pulse restarts it; ready is a one-cycle pulse after the latency.
  logic        stub_en, stub_act, stub_div;
  int unsigned stub_cnt, stub_lat;
  initial begin
    stub_act = 1'b0;
    stub_div = 1'b0;
    stub_cnt = 0;
    stub_lat = 0;
  end
  always @(posedge clock) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      stub_act <= 1'b1;
      stub_cnt <= 1;
      stub_div <= md_ctrl_DIV;
      stub_lat <= md_ctrl_DIV ? DIV_LATENCY : MULT_LATENCY;
    end else if (stub_act) begin
      if (stub_cnt == stub_lat) stub_act <= 1'b0;
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign md_resultRDY = stub_en && stub_act && (stub_cnt == stub_lat);
  always_comb {md_exception, md_result} = ref_op(stub_div, md_operandA, md_operandB);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete operation: issue, wait for writeback, backpressure, handshake.
  task automatic run_op(input string tag, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int unsigned lat,
                        input int unsigned bp, input logic [31:0] exp_d, input logic exp_e,
                        input logic exp_t);
    int unsigned k;
    bit          seen, stable, extra_pulse, hold_ok;
    @(negedge clock);
    issue_valid  = 1'b1;
    issue_is_div = div;
    issue_a      = a;
    issue_b      = b;
    issue_rd     = rd;
    #1;
    check({tag, " issue_ready"}, 64'(issue_ready), 64'd1);
    check({tag, " busy_on_issue"}, 64'(busy), 64'd1);
    @(negedge clock);
    issue_valid = 1'b0;
    issue_a     = $urandom;
    issue_b     = $urandom;
    issue_rd    = 5'($urandom);
    check({tag, " start_pulse"}, 64'({md_ctrl_DIV, md_ctrl_MULT}), 64'({div, !div}));
    k           = 1;
    seen        = 1'b0;
    stable      = 1'b1;
    extra_pulse = 1'b0;
    while (!seen && k < 200) begin
      if (md_operandA !== a || md_operandB !== b) stable = 1'b0;
      if (k > 1 && (md_ctrl_MULT || md_ctrl_DIV)) extra_pulse = 1'b1;
      if (wb_valid) seen = 1'b1;
      else begin
        @(negedge clock);
        k++;
      end
    end
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " operands_stable"}, 64'(stable), 64'd1);
    check({tag, " single_pulse"}, 64'(extra_pulse), 64'd0);
    check({tag, " wb_data"}, 64'(wb_data), 64'(exp_d));
    check({tag, " wb_rd"}, 64'(wb_rd), 64'(rd));
    check({tag, " wb_exc_to"}, 64'({wb_exception, wb_timeout}), 64'({exp_e, exp_t}));
    hold_ok = 1'b1;
    for (int i = 0; i < int'(bp); i++) begin
      @(negedge clock);
      if (!wb_valid || wb_data !== exp_d || wb_rd !== rd || issue_ready || !busy)
        hold_ok = 1'b0;
    end
    check({tag, " hold"}, 64'(hold_ok), 64'd1);
    wb_ready = 1'b1;
    @(negedge clock);
    wb_ready = 1'b0;
    check({tag, " back_to_idle"}, 64'({wb_valid, issue_ready}), 64'b01);
  endtask

  task automatic no_wb_for(input string tag, input int unsigned n);
    int unsigned cnt = 0;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clock);
      if (wb_valid) cnt++;
    end
    check(tag, 64'(cnt), 64'd0);
  endtask

  initial begin
    logic [32:0] r;
    logic        div;
    logic [31:0] a, b;
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0;
    issue_a = '0; issue_b = '0; issue_rd = '0; wb_ready = 1'b0; stub_en = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", 64'({issue_ready, busy, wb_valid, md_ctrl_MULT, md_ctrl_DIV,
                                wb_exception, wb_timeout}), 64'b1000000);
    check("reset_wb_data", 64'({wb_rd, wb_data}), 64'd0);
    reset = 1'b0;

    run_op("mul_neg", 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd5, 19, 0, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("div_neg", 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd9, 36, 0, 32'hFFFF_FFF2, 1'b0, 1'b0);
    run_op("div_zero", 1'b1, 32'd5, 32'd0, 5'd3, 36, 0, 32'd0, 1'b1, 1'b0);
    run_op("mul_ovf", 1'b0, 32'h4000_0000, 32'd4, 5'd1, 19, 0, 32'd0, 1'b1, 1'b0);
    run_op("backpressure", 1'b0, 32'd12, 32'd12, 5'd30, 19, 5, 32'd144, 1'b0, 1'b0);

    // Flush wins over a simultaneous issue.
    @(negedge clock);
    issue_valid = 1'b1; flush = 1'b1; issue_a = 32'd1; issue_b = 32'd1;
    #1;
    check("flush_issue_busy", 64'(busy), 64'd0);
    @(negedge clock);
    issue_valid = 1'b0; flush = 1'b0;
    check("flush_issue_ignored", 64'({issue_ready, md_ctrl_MULT, md_ctrl_DIV}), 64'b100);

    // Flush a divide mid-WAIT; its late ready must never reach writeback.
    @(negedge clock);
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_a = 32'd2; issue_b = 32'd3; issue_rd = 5'd7;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (11) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_wait_idle", 64'({issue_ready, busy}), 64'b10);
    no_wb_for("flush_no_wb", 40);
    run_op("after_flush", 1'b0, 32'd2, 32'd3, 5'd7, 19, 0, 32'd6, 1'b0, 1'b0);

    // Watchdog: the unit never answers.
    stub_en = 1'b0;
    run_op("timeout", 1'b1, 32'd9, 32'd3, 5'd11, TO + 2, 2, 32'd0, 1'b1, 1'b1);
    stub_en = 1'b1;

    // Reset mid-WAIT.
    @(negedge clock);
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_a = 32'd77; issue_b = 32'd5; issue_rd = 5'd4;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_wait_ctrl", 64'({issue_ready, busy, wb_valid, md_ctrl_MULT, md_ctrl_DIV,
                                wb_exception, wb_timeout}), 64'b1000000);
    check("rst_wait_ops", 64'({md_operandA, md_operandB}), 64'd0);
    check("rst_wait_wb", 64'({wb_rd, wb_data}), 64'd0);
    no_wb_for("rst_no_wb", 40);

    // Randomized operations against the reference arithmetic.
    for (int n = 0; n < 24; n++) begin
      div = 1'($urandom);
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 5000)) - 32'd2500 : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 300)) - 32'd150;
      r   = ref_op(div, a, b);
      run_op($sformatf("rand%0d", n), div, a, b, 5'($urandom), div ? 36 : 19,
             $urandom_range(0, 3), r[31:0], r[32], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
